qsys_system_pio_out_blink: RTL and testbench

Parametrised Avalon-MM output PIO that generalises the single-register 8-bit output ports used for the clock's display digits. It adds atomic bit set/clear registers and a per-bit hardware blink engine, so the Nios software can flash individual digits (e.g. while the alarm time is being edited) without periodic rewrites. It sits in the Qsys system as an Avalon slave (`s1`) driving a conduit `out_port`.

---
 rtl/qsys_pio_pkg.sv | 10 +
 rtl/qsys_pio_blink_timer.sv | 33 +++
 rtl/qsys_system_pio_out_blink.sv | 98 +++++++++
 tb/tb_qsys_system_pio_out_blink.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/qsys_pio_pkg.sv
// qsys_pio_pkg: register map shared by the output PIO and its blink timer.
package qsys_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

endpackage

// File: rtl/qsys_pio_blink_timer.sv
// qsys_pio_blink_timer: half-period counter that toggles phase every `period` cycles.
// period == 0 parks the engine at cnt = 0, phase = 0; restart wins over a coincident wrap.
module qsys_pio_blink_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;
  logic                wrap;

  assign wrap = (cnt == period - PERIOD_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart || period == '0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/qsys_system_pio_out_blink.sv
// qsys_system_pio_out_blink: Avalon-MM output PIO with atomic set/clear and per-bit blink.
// Blink engine, BLINK_MASK and BLINK_PERIOD exist only when QSYS_PIO_BLINK_EN is defined.
module qsys_system_pio_out_blink
  import qsys_pio_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned RESET_VALUE  = 64,
  parameter int unsigned PERIOD_W     = 24,
  parameter int unsigned PERIOD_RESET = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             write_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] blank;

  assign write_en = chipselect & ~write_n;
  assign wdata    = writedata[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= WIDTH'(RESET_VALUE);
    end else if (write_en) begin
      case (address)
        ADDR_DATA:   data_out <= wdata;
        ADDR_OUTSET: data_out <= data_out | wdata;
        ADDR_OUTCLR: data_out <= data_out & ~wdata;
        default:     data_out <= data_out;
      endcase
    end
  end

`ifdef QSYS_PIO_BLINK_EN
  logic [WIDTH-1:0]    blink_mask;
  logic [PERIOD_W-1:0] period;
  logic                period_wr;
  logic                phase;
  logic                unused_bits;

  assign period_wr   = write_en && (address == ADDR_PERIOD);
  assign unused_bits = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask <= '0;
      period     <= PERIOD_W'(PERIOD_RESET);
    end else begin
      if (write_en && address == ADDR_MASK) blink_mask <= wdata;
      if (period_wr)                        period     <= writedata[PERIOD_W-1:0];
    end
  end

  qsys_pio_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period),
    .restart (period_wr),
    .phase   (phase)
  );

  assign blank = blink_mask & {WIDTH{phase}};
`else
  logic unused_bits;

  // Blink parameters are accepted but have no hardware behind them in this build.
  assign unused_bits = &{1'b0, writedata, 32'(PERIOD_W), 32'(PERIOD_RESET)};
  assign blank       = '0;
`endif

  assign out_port = data_out & ~blank;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = data_out;
`ifdef QSYS_PIO_BLINK_EN
      ADDR_MASK:   readdata[WIDTH-1:0]    = blink_mask;
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period;
`else
      ADDR_MASK:   readdata = '0;
      ADDR_PERIOD: readdata = '0;
`endif
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_qsys_system_pio_out_blink.sv
// tb_qsys_system_pio_out_blink: scoreboard bench for the output PIO, blink and reset behaviour.
module tb_qsys_system_pio_out_blink;
  import qsys_pio_pkg::*;

  localparam int WIDTH    = 8;
  localparam int PERIOD_W = 24;
`ifdef QSYS_PIO_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // reference model: blink phase derived from cycles elapsed since the last restart
  logic [WIDTH-1:0]    m_data;
  logic [WIDTH-1:0]    m_mask;
  logic [PERIOD_W-1:0] m_period;
  int                  m_t;

  qsys_system_pio_out_blink #(
    .WIDTH        (WIDTH),
    .RESET_VALUE  (64),
    .PERIOD_W     (PERIOD_W),
    .PERIOD_RESET (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_phase();
    if (m_period == '0) return 1'b0;
    return ((m_t / int'(m_period)) % 2) == 1;
  endfunction

  function automatic logic [31:0] model_out();
    return 32'(m_data & ~(m_mask & {WIDTH{model_phase()}}));
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_data);
      3'd1:    return 32'(m_mask);
      3'd2:    return 32'(m_period);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_data   = 8'h40;
    m_mask   = '0;
    m_period = '0;
    m_t      = 0;
  endtask

  // one clock: drive inputs, advance the model at the edge, compare out_port at the next negedge
  task automatic cycle(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd,
                       input string tag);
    logic wr;
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    wr = cs & ~wn;
    @(posedge clk);
    if (wr && a == 3'd2 && BLINK_EN) begin
      m_t = 0;
    end else if (m_period != '0) begin
      m_t++;
    end else begin
      m_t = 0;
    end
    if (wr) begin
      case (a)
        3'd0: m_data = wd[WIDTH-1:0];
        3'd1: if (BLINK_EN) m_mask = wd[WIDTH-1:0];
        3'd2: if (BLINK_EN) m_period = wd[PERIOD_W-1:0];
        3'd4: m_data = m_data | wd[WIDTH-1:0];
        3'd5: m_data = m_data & ~wd[WIDTH-1:0];
        default: ;
      endcase
    end
    exp_q.push_back(model_out());
    @(negedge clk);
    if (exp_q.size() == 0) check({tag, "_q_empty"}, 32'd1, 32'd0);
    else check(tag, 32'(out_port), exp_q.pop_front());
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd, input string tag);
    cycle(a, 1'b1, 1'b0, wd, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(3'd0, 1'b0, 1'b1, 32'h0, tag);
  endtask

  task automatic rd(input logic [2:0] a, input string tag);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    exp_q.push_back(model_read(a));
    check(tag, readdata, exp_q.pop_front());
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out_port), model_out());
    rd(3'd0, "rst_rd0");
    rd(3'd1, "rst_rd1");
    rd(3'd2, "rst_rd2");
    reset_n = 1'b1;
    idle(2, "post_rst");

    // set / clear
    wr(ADDR_DATA, 32'h0000_005A, "data_5a");
    wr(ADDR_OUTSET, 32'h0000_0081, "outset_81");
    wr(ADDR_OUTCLR, 32'h0000_000F, "outclr_0f");
    rd(3'd4, "rd_outset");
    rd(3'd5, "rd_outclr");
    rd(3'd0, "rd_data_d0");
    cycle(ADDR_DATA, 1'b0, 1'b0, 32'h0000_0011, "no_cs_write");
    wr(ADDR_DATA, 32'hFFFF_FF12, "data_upper_ignored");
    rd(3'd0, "rd_data_12");

    // blink P=4
    wr(ADDR_DATA, 32'h0000_00FF, "data_ff");
    wr(ADDR_MASK, 32'h0000_000F, "mask_0f");
    wr(ADDR_PERIOD, 32'd4, "period_4");
    rd(3'd1, "rd_mask");
    rd(3'd2, "rd_period");
    idle(17, "blink4");
    rd(3'd0, "rd_data_blink");

    // restart while blanked
    for (int i = 0; i < 8; i++) begin
      if (model_phase()) break;
      idle(1, "seek_blank");
    end
    wr(ADDR_PERIOD, 32'd4, "restart_blank");
    idle(9, "after_restart");
    // restart on the wrap edge
    for (int i = 0; i < 8; i++) begin
      if (m_period != '0 && (m_t % 4) == 3) break;
      idle(1, "seek_wrap");
    end
    wr(ADDR_PERIOD, 32'd4, "restart_wrap");
    idle(9, "after_wrap");
    wr(ADDR_OUTSET, 32'h0000_0000, "outset_keeps_timer");
    idle(5, "timer_kept");

    // short periods
    wr(ADDR_PERIOD, 32'd1, "period_1");
    idle(4, "blink1");
    wr(ADDR_PERIOD, 32'hFF00_0003, "period_3_upper");
    idle(8, "blink3");

    // period 0 holds steady
    wr(ADDR_MASK, 32'h0000_00FF, "mask_ff");
    wr(ADDR_PERIOD, 32'd0, "period_0");
    idle(6, "steady");

    // unmapped addresses
    wr(3'd7, 32'hFFFF_FFFF, "wr_addr7");
    wr(3'd3, 32'hFFFF_FFFF, "wr_addr3");
    wr(3'd6, 32'h0000_0000, "wr_addr6");
    for (int a = 0; a < 8; a++) rd(3'(a), $sformatf("rd_all%0d", a));

    // async reset mid-blink
    wr(ADDR_DATA, 32'h0000_00AA, "data_aa");
    wr(ADDR_PERIOD, 32'd2, "period_2");
    idle(3, "pre_reset");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_out", 32'(out_port), model_out());
    rd(3'd1, "async_rst_rd1");
    rd(3'd2, "async_rst_rd2");
    @(negedge clk);
    reset_n = 1'b1;
    idle(2, "after_rst");
    wr(ADDR_OUTCLR, 32'h0000_0040, "resume_clr");
    rd(3'd0, "resume_rd0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
